// File: rtl/tc_pl_cap_data_acprx_crc_chk.sv
// Receive-side CRC-32 checker for the capture data path: accumulates CRC over 64-bit data beats,
// compares against the trailing CRC beat and reports pass/fail, frame length and error count.
module tc_pl_cap_data_acprx_crc_chk #(
    parameter int unsigned CAP0_8    = 32,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              crc_en,
    input  logic [63:0]       rx_data,
    input  logic              rx_valid,
    input  logic              rx_sof,
    input  logic              rx_crc_last,
    output logic [CAP0_8-1:0] crc_calc,
    output logic [CAP0_8-1:0] crc_rx,
    output logic              chk_done,
    output logic              chk_ok,
    output logic              chk_err,
    output logic              len_err,
    output logic [CNT_W-1:0]  frame_words,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam logic [CAP0_8-1:0] POLY = CAP0_8'(32'h04C11DB7);

    typedef enum logic [1:0] {StIdle, StData, StDrop, StResult} state_e;

    state_e            state_q, state_d;
    logic [CAP0_8-1:0] crc_q, crc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frm_lerr_q, frm_lerr_d;
    logic [CAP0_8-1:0] crc_calc_q, crc_calc_d;
    logic [CAP0_8-1:0] crc_rx_q, crc_rx_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              len_err_q, len_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              start;
    logic              crc_match;

    // Non-reflected, MSB-first: rx_data[63] enters the register first.
    function automatic logic [CAP0_8-1:0] crc_step(input logic [CAP0_8-1:0] c,
                                                   input logic [63:0] d);
        logic [CAP0_8-1:0] r;
        r = c;
        for (int i = 63; i >= 0; i--) begin
            if (r[CAP0_8-1] ^ d[i]) begin
                r = {r[CAP0_8-2:0], 1'b0} ^ POLY;
            end else begin
                r = {r[CAP0_8-2:0], 1'b0};
            end
        end
        return r;
    endfunction

    assign crc_match = (crc_calc_q == crc_rx_q);

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        frm_lerr_d = frm_lerr_q;
        crc_calc_d = crc_calc_q;
        crc_rx_d   = crc_rx_q;
        words_d    = words_q;
        len_err_d  = len_err_q;
        err_cnt_d  = err_cnt_q;
        chk_done   = 1'b0;
        chk_ok     = 1'b0;
        chk_err    = 1'b0;
        start      = 1'b0;

        if (!crc_en) begin
            state_d = StIdle;
            crc_d   = '1;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_valid && rx_sof) start = 1'b1;
                end
                StData, StDrop: begin
                    if (rx_valid) begin
                        if (rx_sof) begin
                            // Abort: report the unfinished frame now, then restart on this beat.
                            chk_done  = 1'b1;
                            chk_err   = 1'b1;
                            len_err_d = 1'b1;
                            start     = 1'b1;
                        end else if (rx_crc_last) begin
                            crc_rx_d = rx_data[CAP0_8-1:0];
                            state_d  = StResult;
                            if (state_q == StData) begin
                                crc_calc_d = crc_q ^ '1;
                                words_d    = cnt_q;
                            end else begin
                                words_d = CNT_W'(MAX_WORDS);
                            end
                        end else if (state_q == StData) begin
                            if (cnt_q < CNT_W'(MAX_WORDS)) begin
                                crc_d = crc_step(crc_q, rx_data);
                                cnt_d = cnt_q + 1'b1;
                            end else begin
                                len_err_d  = 1'b1;
                                frm_lerr_d = 1'b1;
                                state_d    = StDrop;
                            end
                        end
                    end
                end
                StResult: begin
                    chk_done = 1'b1;
                    chk_ok   = crc_match && !frm_lerr_q;
                    chk_err  = !chk_ok;
                    if (chk_ok) len_err_d = 1'b0;
                    state_d = StIdle;
                    if (rx_valid && rx_sof) start = 1'b1;
                end
                default: state_d = StIdle;
            endcase

            if (start) begin
                frm_lerr_d = 1'b0;
                if (rx_crc_last) begin
                    // Zero-length frame: init ^ final XOR leaves an all-zero CRC.
                    crc_calc_d = '0;
                    crc_rx_d   = rx_data[CAP0_8-1:0];
                    words_d    = '0;
                    crc_d      = '1;
                    cnt_d      = '0;
                    state_d    = StResult;
                end else begin
                    crc_d   = crc_step('1, rx_data);
                    cnt_d   = CNT_W'(1);
                    state_d = StData;
                end
            end

            if (chk_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            crc_q      <= '1;
            cnt_q      <= '0;
            frm_lerr_q <= 1'b0;
            crc_calc_q <= '0;
            crc_rx_q   <= '0;
            words_q    <= '0;
            len_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            frm_lerr_q <= frm_lerr_d;
            crc_calc_q <= crc_calc_d;
            crc_rx_q   <= crc_rx_d;
            words_q    <= words_d;
            len_err_q  <= len_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign crc_calc    = crc_calc_q;
    assign crc_rx      = crc_rx_q;
    assign frame_words = words_q;
    assign len_err     = len_err_q;
    assign err_cnt     = err_cnt_q;
    assign busy        = (state_q == StData) || (state_q == StDrop);

endmodule

// File: tb/tb_tc_pl_cap_data_acprx_crc_chk.sv
// Scoreboard bench for the receive CRC checker: expected results are queued as frames are
// driven and matched against chk_done pulses captured on the falling clock edge.
module tb_tc_pl_cap_data_acprx_crc_chk;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        crc_en = 1'b0;
    logic [63:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_sof = 1'b0;
    logic        rx_crc_last = 1'b0;
    logic [31:0] crc_calc, crc_rx;
    logic        chk_done, chk_ok, chk_err, len_err, busy;
    logic [15:0] frame_words, err_cnt;

    always #5 clk = ~clk;

    tc_pl_cap_data_acprx_crc_chk #(
        .CAP0_8   (32),
        .MAX_WORDS(MW),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .crc_en     (crc_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_crc_last(rx_crc_last),
        .crc_calc   (crc_calc),
        .crc_rx     (crc_rx),
        .chk_done   (chk_done),
        .chk_ok     (chk_ok),
        .chk_err    (chk_err),
        .len_err    (len_err),
        .frame_words(frame_words),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    typedef struct packed {
        logic        ok;
        logic        err;
        logic        full;    // compare words and rx
        logic        calc_v;  // compare calc
        logic [15:0] words;
        logic [31:0] calc;
        logic [31:0] rx;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t mon_r;
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_err_cnt = 0;
    logic exp_len_err = 1'b0;

    always @(negedge clk) begin
        if (chk_done) begin
            mon_r       = '0;
            mon_r.ok    = chk_ok;
            mon_r.err   = chk_err;
            mon_r.words = frame_words;
            mon_r.calc  = crc_calc;
            mon_r.rx    = crc_rx;
            obs_q.push_back(mon_r);
        end
    end

    function automatic logic [63:0] word(input logic [63:0] seed, input int k);
        return seed + 64'(k) * 64'h0808080808080808;
    endfunction

    // Bit-serial reference CRC-32 (poly 0x04C11DB7, MSB first, init/xorout all-ones).
    function automatic logic [31:0] model_crc(input logic [63:0] seed, input int n);
        logic [31:0] c;
        logic [63:0] w;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            w = word(seed, k);
            for (int b = 63; b >= 0; b--) begin
                fb = c[31] ^ w[b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic beat(input logic v, input logic sof, input logic last, input logic [63:0] d);
        rx_valid    = v;
        rx_sof      = sof;
        rx_crc_last = last;
        rx_data     = d;
        @(posedge clk);
        #1;
        rx_valid    = 1'b0;
        rx_sof      = 1'b0;
        rx_crc_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives n data beats (gap idle cycles between beats) and the CRC beat; queues the expectation.
    task automatic send_frame(input logic [63:0] seed, input int n, input int gap,
                              input logic [31:0] flip);
        logic [31:0] crc;
        res_t        e;
        crc = model_crc(seed, n) ^ flip;
        for (int k = 0; k < n; k++) begin
            beat(1'b1, k == 0, 1'b0, word(seed, k));
            idle(gap);
        end
        beat(1'b1, n == 0, 1'b1, {32'hDEADBEEF, crc});
        e        = '0;
        e.full   = 1'b1;
        e.words  = 16'((n > MW) ? MW : n);
        e.rx     = crc;
        e.calc_v = (n <= MW);
        e.calc   = model_crc(seed, n);
        e.ok     = (n <= MW) && (flip == 32'h0);
        e.err    = !e.ok;
        exp_q.push_back(e);
        if (e.err) exp_err_cnt++;
        if (e.ok) exp_len_err = 1'b0;
        if (n > MW) exp_len_err = 1'b1;
    endtask

    task automatic test_reset;
        idle(1);
        n_checks++;
        if (crc_calc !== 32'h0 || crc_rx !== 32'h0 || chk_done !== 1'b0 || chk_ok !== 1'b0 ||
            chk_err !== 1'b0 || len_err !== 1'b0 || frame_words !== 16'h0 ||
            err_cnt !== 16'h0 || busy !== 1'b0) begin
            $display("FAIL reset_values: got calc=%h rx=%h done=%b ok=%b err=%b lerr=%b words=%0d cnt=%0d busy=%b want all zero",
                     crc_calc, crc_rx, chk_done, chk_ok, chk_err, len_err, frame_words, err_cnt, busy);
        end else n_pass++;
        rst    = 1'b1;
        crc_en = 1'b1;
        idle(2);
        n_checks++;
        if (busy !== 1'b0 || chk_done !== 1'b0) begin
            $display("FAIL post_reset_idle: got busy=%b done=%b want 0 0", busy, chk_done);
        end else n_pass++;
    endtask

    task automatic test_zero_len;
        send_frame(64'h0, 0, 0, 32'h0);
        n_checks++;
        if (chk_done !== 1'b1 || chk_ok !== 1'b1 || frame_words !== 16'h0 || crc_calc !== 32'h0) begin
            $display("FAIL zero_len_timing: got done=%b ok=%b words=%0d calc=%h want 1 1 0 00000000",
                     chk_done, chk_ok, frame_words, crc_calc);
        end else n_pass++;
        idle(1);
        n_checks++;
        if (chk_done !== 1'b0) begin
            $display("FAIL zero_len_pulse_width: got done=%b want 0", chk_done);
        end else n_pass++;
        idle(1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL zero_len_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            res_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.ok !== e.ok || o.err !== e.err || (e.full && (o.words !== e.words || o.rx !== e.rx)) ||
                (e.calc_v && o.calc !== e.calc)) begin
                $display("FAIL zero_len_result: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                         o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
            end else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_good_frame;
        for (int pass = 0; pass < 2; pass++) begin
            send_frame(64'h0001020304050607, 4, 0, (pass == 0) ? 32'h0 : 32'h1);
            idle(2);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                $display("FAIL frame4_count: got %0d results want %0d", obs_q.size(), exp_q.size());
            end else n_pass++;
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                res_t e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.ok !== e.ok || o.err !== e.err || (e.full && (o.words !== e.words || o.rx !== e.rx)) ||
                    (e.calc_v && o.calc !== e.calc)) begin
                    $display("FAIL frame4_result: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                             o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
                end else n_pass++;
            end
            exp_q.delete();
            obs_q.delete();
            n_checks++;
            if (err_cnt !== 16'(exp_err_cnt) || len_err !== exp_len_err) begin
                $display("FAIL frame4_status: got err_cnt=%0d len_err=%b want %0d %b",
                         err_cnt, len_err, exp_err_cnt, exp_len_err);
            end else n_pass++;
        end
    endtask

    task automatic test_gapped;
        send_frame(64'h0001020304050607, 4, 3, 32'h0);
        idle(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL gapped_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            res_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.ok !== e.ok || o.err !== e.err || (e.full && (o.words !== e.words || o.rx !== e.rx)) ||
                (e.calc_v && o.calc !== e.calc)) begin
                $display("FAIL gapped_result: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                         o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
            end else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(64'h0001020304050607, 4, 0, 32'h0);
        send_frame(64'hA5A55A5A0F0FF0F0, 3, 0, 32'h0);
        idle(2);
        n_checks++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            $display("FAIL b2b_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            res_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.ok !== e.ok || o.err !== e.err || (e.full && (o.words !== e.words || o.rx !== e.rx)) ||
                (e.calc_v && o.calc !== e.calc)) begin
                $display("FAIL b2b_result: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                         o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
            end else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_overflow;
        for (int pass = 0; pass < 2; pass++) begin
            send_frame(64'h1122334455667788, (pass == 0) ? 10 : 4, 0, 32'h0);
            idle(2);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                $display("FAIL overflow_count: got %0d results want %0d", obs_q.size(), exp_q.size());
            end else n_pass++;
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                res_t e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++;
                if (o.ok !== e.ok || o.err !== e.err || (e.full && (o.words !== e.words || o.rx !== e.rx)) ||
                    (e.calc_v && o.calc !== e.calc)) begin
                    $display("FAIL overflow_result: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                             o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
                end else n_pass++;
            end
            exp_q.delete();
            obs_q.delete();
            n_checks++;
            if (err_cnt !== 16'(exp_err_cnt) || len_err !== exp_len_err) begin
                $display("FAIL overflow_status: got err_cnt=%0d len_err=%b want %0d %b",
                         err_cnt, len_err, exp_err_cnt, exp_len_err);
            end else n_pass++;
        end
    endtask

    task automatic test_abort;
        res_t a;
        beat(1'b1, 1'b1, 1'b0, word(64'hCAFEF00D00000000, 0));
        beat(1'b1, 1'b0, 1'b0, word(64'hCAFEF00D00000000, 1));
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL abort_busy: got busy=%b want 1", busy);
        end else n_pass++;
        a     = '0;
        a.err = 1'b1;
        exp_q.push_back(a);
        exp_err_cnt++;
        exp_len_err = 1'b1;
        send_frame(64'h0001020304050607, 4, 0, 32'h0);
        idle(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL abort_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            res_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.ok !== e.ok || o.err !== e.err || (e.full && (o.words !== e.words || o.rx !== e.rx)) ||
                (e.calc_v && o.calc !== e.calc)) begin
                $display("FAIL abort_result: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                         o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
            end else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (err_cnt !== 16'(exp_err_cnt) || len_err !== exp_len_err) begin
            $display("FAIL abort_status: got err_cnt=%0d len_err=%b want %0d %b",
                     err_cnt, len_err, exp_err_cnt, exp_len_err);
        end else n_pass++;
    endtask

    task automatic test_enable_drop;
        beat(1'b1, 1'b1, 1'b0, word(64'h0F1E2D3C4B5A6978, 0));
        beat(1'b1, 1'b0, 1'b0, word(64'h0F1E2D3C4B5A6978, 1));
        crc_en = 1'b0;
        beat(1'b1, 1'b0, 1'b0, word(64'h0F1E2D3C4B5A6978, 2));
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL en_drop_busy: got busy=%b want 0", busy);
        end else n_pass++;
        crc_en = 1'b1;
        beat(1'b1, 1'b0, 1'b1, {32'h0, model_crc(64'h0F1E2D3C4B5A6978, 3)});
        idle(2);
        n_checks++;
        if (obs_q.size() != 0 || err_cnt !== 16'(exp_err_cnt)) begin
            $display("FAIL en_drop_silent: got %0d results err_cnt=%0d want 0 results err_cnt=%0d",
                     obs_q.size(), err_cnt, exp_err_cnt);
        end else n_pass++;
        obs_q.delete();
        send_frame(64'h0001020304050607, 4, 0, 32'h0);
        idle(2);
        while (exp_q.size() > 0) begin
            res_t e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            n_checks++;
            if (o.ok !== e.ok || o.err !== e.err || o.words !== e.words || o.rx !== e.rx ||
                o.calc !== e.calc) begin
                $display("FAIL en_drop_next_frame: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                         o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
            end else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        beat(1'b1, 1'b1, 1'b0, word(64'h0001020304050607, 0));
        beat(1'b1, 1'b0, 1'b0, word(64'h0001020304050607, 1));
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || err_cnt !== 16'h0 || len_err !== 1'b0 || crc_calc !== 32'h0 ||
            frame_words !== 16'h0 || chk_done !== 1'b0) begin
            $display("FAIL rst_mid_frame: got busy=%b err_cnt=%0d lerr=%b calc=%h words=%0d done=%b want all zero",
                     busy, err_cnt, len_err, crc_calc, frame_words, chk_done);
        end else n_pass++;
        exp_err_cnt = 0;
        exp_len_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        send_frame(64'h0001020304050607, 4, 0, 32'h0);
        idle(2);
        n_checks++;
        if (obs_q.size() != 1) begin
            $display("FAIL rst_next_count: got %0d results want 1", obs_q.size());
        end else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            res_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.ok !== e.ok || o.err !== e.err || o.words !== e.words || o.rx !== e.rx ||
                o.calc !== e.calc) begin
                $display("FAIL rst_next_frame: got ok=%b err=%b words=%0d calc=%h rx=%h want ok=%b err=%b words=%0d calc=%h rx=%h",
                         o.ok, o.err, o.words, o.calc, o.rx, e.ok, e.err, e.words, e.calc, e.rx);
            end else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (err_cnt !== 16'h0) begin
            $display("FAIL rst_err_cnt: got %0d want 0", err_cnt);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_good_frame();
        test_gapped();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_enable_drop();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tc_pl_cap_data_acprx_crc_chk.md
Name: tc_pl_cap_data_acprx_crc_chk

Overview:
Receive-side CRC checker for the capture data path. It sits behind the link receiver and pairs with the transmit-side CRC32 generator. It accumulates CRC-32 over a frame of 64-bit words, compares the result against the CRC word that ends the frame, and reports pass/fail, frame length, and an error count to the status/AXI-lite register block.

Parameters:
CAP0_8, 32, CRC width; fixed at 32, other values are unsupported.
MAX_WORDS, 1024, maximum number of data beats per frame, excluding the CRC beat.
CNT_W, 16, width of the word and error counters.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
crc_en  in  1  block enable; when low, input is ignored and the FSM returns to IDLE
rx_data  in  64  frame beat; data beat, or CRC beat with the CRC in [31:0]
rx_valid  in  1  rx_data is valid this cycle; there is no backpressure
rx_sof  in  1  first beat of a frame; qualified by rx_valid
rx_crc_last  in  1  this beat is the CRC beat and closes the frame; qualified by rx_valid
crc_calc  out  32  CRC computed for the last closed frame
crc_rx  out  32  CRC received for the last closed frame
chk_done  out  1  one-cycle pulse when a result is valid
chk_ok  out  1  one-cycle pulse with chk_done when crc_calc == crc_rx and no length error
chk_err  out  1  one-cycle pulse with chk_done on CRC mismatch or length error
len_err  out  1  sticky flag, set on frame overflow or abort; cleared by the next chk_ok
frame_words  out  CNT_W  data-beat count of the last closed frame
err_cnt  out  CNT_W  saturating count of chk_err pulses
busy  out  1  high while the FSM is in DATA or DROP

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, FSM = IDLE, CRC register = 0xFFFFFFFF.
- CRC algorithm: polynomial 0x04C11DB7, non-reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Bit rx_data[63] is the first bit in. One full 64-bit step is computed combinationally per cycle, identical to the transmit generator.
- FSM states: IDLE, DATA, DROP, RESULT.
- IDLE:
  - rx_valid & rx_sof & !rx_crc_last: CRC register = step(0xFFFFFFFF, rx_data); word count = 1; go to DATA.
  - rx_valid & rx_sof & rx_crc_last (zero-length frame): computed CRC = 0x00000000, latch crc_rx; go to RESULT.
  - Beats without sof are ignored.
- DATA, rx_valid & !rx_sof & !rx_crc_last:
  - Word count < MAX_WORDS: step CRC, word count++.
  - Otherwise: len_err=1, go to DROP.
- DATA, rx_valid & rx_crc_last: latch crc_rx = rx_data[31:0] and crc_calc = CRC register ^ 0xFFFFFFFF; latch frame_words; go to RESULT.
- DATA, rx_valid & rx_sof (abort): len_err=1, emit chk_err for the aborted frame in the same cycle, then restart as in IDLE with this beat.
- DROP: ignore data beats. On rx_crc_last, latch crc_rx and frame_words = MAX_WORDS, then go to RESULT (which reports chk_err). An sof in DROP is handled as the DATA abort case.
- RESULT (one cycle): chk_done=1; chk_ok or chk_err per the compare and len_err. Go to IDLE. The result therefore appears exactly one cycle after the CRC beat.
- Back-to-back frames: an sof beat arriving during RESULT is accepted and processed as in IDLE in that same cycle; no beat is ever lost.
- Idle cycles (rx_valid=0) anywhere hold all state.
- crc_en=0: ignore input, force IDLE, drop any in-flight frame with no chk_done. Latched outputs and err_cnt are held.
- err_cnt saturates at all-ones; it is not cleared except by reset.
- Reset asserted mid-frame: immediate return to reset values; no result pulse.

Test Plan:
- Zero-length frame: sof+crc_last with rx_data[31:0]=0x00000000 -> chk_done/chk_ok one cycle later, frame_words=0, crc_calc=0x00000000.
- 4-word frame 0x0001020304050607..0x18191A1B1C1D1E1F followed by the CRC from the bench's bit-serial model (also loopback from the transmit generator) -> chk_ok, frame_words=4, crc_calc == crc_rx. Same frame with bit 0 of the CRC flipped -> chk_err, err_cnt=1.
- Gapped stream: the 4-word frame with rx_valid=0 for 3 cycles between each beat -> identical result to the ungapped run. Back-to-back frames with sof in the RESULT cycle -> two chk_done pulses, both ok.
- MAX_WORDS=8, send 10 data beats then CRC -> len_err=1, chk_err, frame_words=8. Next good frame -> chk_ok, len_err cleared.
- sof after 2 data beats -> chk_err pulse in the abort cycle; the new frame completes with chk_ok.
- crc_en dropped mid-frame, and rst pulsed mid-frame -> no chk_done, busy=0; rst also zeroes err_cnt. A following good frame checks ok.
